// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared types and constants for the BMQ receive frame synchroniser
package decoder_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } dec_state_t;

    localparam int         BITS_PER_CHANNEL  = 8;
    localparam logic [6:0] CH_SYNC           = 7'd0;
    localparam logic [6:0] CH_FRAME_HI       = 7'd1;
    localparam logic [6:0] CH_FRAME_LO       = 7'd2;
    localparam logic [7:0] DEFAULT_SYNC_WORD = 8'hA5;

    // MSB-first deserialisation: the newest bit enters at the bottom
    function automatic logic [7:0] shift_in(input logic [7:0] sr, input logic b);
        return {sr[6:0], b};
    endfunction

endpackage

// File: rtl/decoder_position_counter.sv
// rtl/decoder_position_counter.sv - loadable channel/bit position counter for the receive frame
module decoder_position_counter
    import decoder_pkg::*;
#(
    parameter int CHANNELS = 128
) (
    input  logic       CLOCK_BMQ,
    input  logic       RESET_N,
    input  logic       enable,
    input  logic       load,
    input  logic       clear,
    output logic [6:0] channel,
    output logic [2:0] bit_idx,
    output logic       byte_done,
    output logic       sync_done
);

    // Position of the next bit to arrive: {channel, bit}, last bit of the frame wraps to (0, 0)
    localparam logic [2:0] LAST_BIT = 3'(BITS_PER_CHANNEL - 1);
    localparam logic [9:0] POS_LAST = {7'(CHANNELS - 1), LAST_BIT};

    logic [9:0] pos;

    assign channel   = pos[9:3];
    assign bit_idx   = pos[2:0];
    assign byte_done = enable && (bit_idx == LAST_BIT);
    assign sync_done = byte_done && (channel == CH_SYNC);

    // Load wins over clear, clear wins over counting; load lands just past a freshly found sync byte
    always_ff @(posedge CLOCK_BMQ or negedge RESET_N) begin
        if (!RESET_N) begin
            pos <= '0;
        end else if (load) begin
            pos <= {CH_FRAME_HI, 3'd0};
        end else if (clear) begin
            pos <= '0;
        end else if (enable) begin
            pos <= (pos == POS_LAST) ? '0 : pos + 10'd1;
        end
    end

endmodule

// File: rtl/decoder_frame_sync.sv
// rtl/decoder_frame_sync.sv - BMQ frame hunt/verify/lock and byte delivery; option DECODER_FRAME_CHECK_EN
module decoder_frame_sync
    import decoder_pkg::*;
#(
    parameter logic [7:0] SYNC_WORD   = DEFAULT_SYNC_WORD,
    parameter int         CHANNELS    = 128,
    parameter int         LOCK_FRAMES = 3,
    parameter int         LOSS_FRAMES = 2
) (
    input  logic        CLOCK_BMQ,
    input  logic        RESET_N,
    input  logic        Data_In,
    input  logic        Bit_Valid,
    output logic [7:0]  Byte_Data,
    output logic        Byte_Valid,
    output logic [6:0]  Counter_Channel,
    output logic [2:0]  Counter_Bits,
    output logic [15:0] Counter_Frame,
    output logic        Locked,
    output logic        Frame_Error
);

    dec_state_t state;
    logic [7:0] shift_reg;
    logic [7:0] byte_next;
    logic [7:0] frame_hi;
    logic [3:0] match_cnt;
    logic [3:0] miss_cnt;

    logic [6:0] channel;
    logic       byte_done;
    logic       sync_done;
    logic       sync_ok;
    logic       pos_enable;
    logic       hunt_hit;
    logic       verify_fail;
    logic       lock_loss;

    assign byte_next   = shift_in(shift_reg, Data_In);
    assign sync_ok     = (byte_next == SYNC_WORD);
    assign pos_enable  = Bit_Valid && (state != HUNT);
    assign hunt_hit    = (state == HUNT) && Bit_Valid && sync_ok;
    assign verify_fail = (state == VERIFY) && sync_done && !sync_ok;
    assign lock_loss   = (state == LOCKED) && sync_done && !sync_ok
                         && ((miss_cnt + 4'd1) >= 4'(LOSS_FRAMES));

    decoder_position_counter #(
        .CHANNELS (CHANNELS)
    ) u_position (
        .CLOCK_BMQ (CLOCK_BMQ),
        .RESET_N   (RESET_N),
        .enable    (pos_enable),
        .load      (hunt_hit),
        .clear     (verify_fail || lock_loss),
        .channel   (channel),
        .bit_idx   (Counter_Bits),
        .byte_done (byte_done),
        .sync_done (sync_done)
    );

    // Sync state machine, deserialiser and registered byte/frame outputs
    always_ff @(posedge CLOCK_BMQ or negedge RESET_N) begin
        if (!RESET_N) begin
            state           <= HUNT;
            shift_reg       <= '0;
            frame_hi        <= '0;
            match_cnt       <= '0;
            miss_cnt        <= '0;
            Byte_Data       <= '0;
            Byte_Valid      <= 1'b0;
            Counter_Channel <= '0;
            Counter_Frame   <= '0;
            Locked          <= 1'b0;
        end else begin
            Byte_Valid <= 1'b0;
            if (Bit_Valid) begin
                shift_reg <= byte_next;
            end
            case (state)
                HUNT: begin
                    if (hunt_hit) begin
                        state     <= VERIFY;
                        match_cnt <= 4'd1;
                    end
                end
                VERIFY: begin
                    if (sync_done) begin
                        if (sync_ok) begin
                            match_cnt <= match_cnt + 4'd1;
                            if ((match_cnt + 4'd1) >= 4'(LOCK_FRAMES)) begin
                                state    <= LOCKED;
                                Locked   <= 1'b1;
                                miss_cnt <= '0;
                            end
                        end else begin
                            // Shift register keeps its contents so hunting resumes on the live stream
                            state     <= HUNT;
                            match_cnt <= '0;
                        end
                    end
                end
                LOCKED: begin
                    if (byte_done) begin
                        // The byte is delivered even when this same bit drops lock
                        Byte_Valid      <= 1'b1;
                        Byte_Data       <= byte_next;
                        Counter_Channel <= channel;
                        if (channel == CH_FRAME_HI) begin
                            frame_hi <= byte_next;
                        end
                        if (channel == CH_FRAME_LO) begin
                            Counter_Frame <= {frame_hi, byte_next};
                        end
                        if (channel == CH_SYNC) begin
                            if (sync_ok) begin
                                miss_cnt <= '0;
                            end else if (lock_loss) begin
                                state     <= HUNT;
                                Locked    <= 1'b0;
                                miss_cnt  <= '0;
                                match_cnt <= '0;
                            end else begin
                                miss_cnt <= miss_cnt + 4'd1;
                            end
                        end
                    end
                end
                default: begin
                    state  <= HUNT;
                    Locked <= 1'b0;
                end
            endcase
        end
    end

`ifdef DECODER_FRAME_CHECK_EN
    logic [15:0] prev_frame;
    logic        prev_seeded;
    logic [15:0] frame_rx;
    logic        frame_lo_done;

    assign frame_rx      = {frame_hi, byte_next};
    assign frame_lo_done = (state == LOCKED) && byte_done && (channel == CH_FRAME_LO);

    // Frame-number continuity: the first frame after each lock only seeds the reference
    always_ff @(posedge CLOCK_BMQ or negedge RESET_N) begin
        if (!RESET_N) begin
            prev_frame  <= '0;
            prev_seeded <= 1'b0;
            Frame_Error <= 1'b0;
        end else begin
            Frame_Error <= 1'b0;
            if (state != LOCKED) begin
                prev_seeded <= 1'b0;
            end else if (frame_lo_done) begin
                Frame_Error <= prev_seeded && (frame_rx != (prev_frame + 16'd1));
                prev_frame  <= frame_rx;
                prev_seeded <= 1'b1;
            end
        end
    end
`else
    assign Frame_Error = 1'b0;
`endif

endmodule

// File: tb/tb_decoder_frame_sync.sv
// tb/tb_decoder_frame_sync.sv - scoreboard bench for decoder_frame_sync
module tb_decoder_frame_sync;

`ifdef DECODER_FRAME_CHECK_EN
    localparam bit FCHK = 1'b1;
`else
    localparam bit FCHK = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] data;
        logic [6:0] ch;
        logic       ferr;
    } exp_t;

    logic        clk = 1'b0;
    logic        RESET_N;
    logic        Data_In;
    logic        Bit_Valid;
    logic [7:0]  Byte_Data;
    logic        Byte_Valid;
    logic [6:0]  Counter_Channel;
    logic [2:0]  Counter_Bits;
    logic [15:0] Counter_Frame;
    logic        Locked;
    logic        Frame_Error;
    logic [36:0] outs;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   strobe_cnt = 0;
    int   snap;
    bit   watch_nolock = 0;
    bit   nolock_viol = 0;

    assign outs = {Byte_Data, Byte_Valid, Counter_Channel, Counter_Bits, Counter_Frame, Locked, Frame_Error};

    always #5 clk = ~clk;

    decoder_frame_sync dut (
        .CLOCK_BMQ       (clk),
        .RESET_N         (RESET_N),
        .Data_In         (Data_In),
        .Bit_Valid       (Bit_Valid),
        .Byte_Data       (Byte_Data),
        .Byte_Valid      (Byte_Valid),
        .Counter_Channel (Counter_Channel),
        .Counter_Bits    (Counter_Bits),
        .Counter_Frame   (Counter_Frame),
        .Locked          (Locked),
        .Frame_Error     (Frame_Error)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [7:0] frame_byte(input logic [15:0] fn, input logic [7:0] sync, input int ch);
        if (ch == 0) return sync;
        if (ch == 1) return fn[15:8];
        if (ch == 2) return fn[7:0];
        return 8'(ch * 37) ^ fn[7:0];
    endfunction

    task automatic send_bit(input logic b, input int gap);
        @(negedge clk);
        Data_In   = b;
        Bit_Valid = 1'b1;
        repeat (gap) begin
            @(negedge clk);
            Bit_Valid = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input int gap);
        for (int i = 7; i >= 0; i--) send_bit(d[i], gap);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            Bit_Valid = 1'b0;
        end
    endtask

    // Push the expected strobe for each channel at or past strobe_from, then serialise it
    task automatic send_chans(input logic [15:0] fn, input logic [7:0] sync, input int from_ch,
                              input int to_ch, input int strobe_from, input bit ferr, input int gap);
        logic [7:0] b;
        for (int ch = from_ch; ch <= to_ch; ch++) begin
            b = frame_byte(fn, sync, ch);
            if (ch >= strobe_from) exp_q.push_back('{b, 7'(ch), FCHK && ferr && (ch == 2)});
            send_byte(b, gap);
        end
    endtask

    // Monitor: every strobe must match the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (watch_nolock && Locked) nolock_viol = 1'b1;
        if (Byte_Valid === 1'b1) begin
            strobe_cnt++;
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_strobe: got channel %0d data %0h, required no strobe", Counter_Channel, Byte_Data);
            end else begin
                e = exp_q.pop_front();
                check("byte_data", Byte_Data, e.data);
                check("byte_channel", Counter_Channel, e.ch);
                check("frame_error", Frame_Error, e.ferr);
            end
        end else if (Frame_Error === 1'b1) begin
            n_total++;
            $display("FAIL stray_frame_error: got 1 without Byte_Valid, required 0");
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        RESET_N   = 1'b0;
        Data_In   = 1'b0;
        Bit_Valid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", outs, 0);
        @(negedge clk) RESET_N = 1'b1;

        // False sync: lone A5 inside filler, next channel-0 slot is not sync
        watch_nolock = 1'b1;
        send_byte(8'h3C, 1);
        send_byte(8'h3C, 1);
        send_byte(8'hA5, 1);
        send_bit(0, 1); send_bit(0, 1); send_bit(1, 1);
        check("verify_bits", Counter_Bits, 3);
        send_bit(1, 1); send_bit(1, 1); send_bit(1, 1); send_bit(0, 1); send_bit(0, 1);
        for (int ch = 2; ch < 128; ch++) send_byte(8'h3C, 1);
        send_byte(8'h3C, 1);
        check("false_sync_hunt_bits", Counter_Bits, 0);
        send_byte(8'h3C, 1);
        send_bit(0, 1); send_bit(0, 1);
        check("hunt_bits_stay_zero", Counter_Bits, 0);
        check("false_sync_never_locked", nolock_viol, 0);
        watch_nolock = 1'b0;

        // Acquisition with a bit every other cycle
        @(negedge clk) RESET_N = 1'b0;
        @(negedge clk) RESET_N = 1'b1;
        repeat (4) send_byte(8'h3C, 1);
        send_chans(16'h0003, 8'hA5, 0, 127, 128, 0, 1);
        send_chans(16'h0004, 8'hA5, 0, 127, 128, 0, 1);
        check("unlocked_before_third_sync", Locked, 0);
        send_chans(16'h0005, 8'hA5, 0, 0, 128, 0, 1);
        check("locked_after_third_sync", Locked, 1);
        send_chans(16'h0005, 8'hA5, 1, 127, 1, 0, 1);
        snap = strobe_cnt;
        send_chans(16'h0007, 8'hA5, 0, 127, 0, 1, 1);
        check("strobes_per_frame", strobe_cnt - snap, 128);
        check("counter_frame_skip", Counter_Frame, 16'h0007);

        // Loss of lock
        send_chans(16'h0008, 8'h5A, 0, 127, 0, 0, 1);
        check("one_bad_sync_keeps_lock", Locked, 1);
        send_chans(16'h0009, 8'hA5, 0, 127, 0, 0, 1);
        send_chans(16'h000A, 8'h5A, 0, 127, 0, 0, 1);
        check("first_of_two_bad_keeps_lock", Locked, 1);
        send_chans(16'h000B, 8'h5A, 0, 0, 0, 0, 1);
        check("second_bad_drops_lock", Locked, 0);

        // Back-to-back bits across the 16-bit frame-number wrap
        @(negedge clk) RESET_N = 1'b0;
        @(negedge clk) RESET_N = 1'b1;
        snap = strobe_cnt;
        send_byte(8'h3C, 0);
        send_byte(8'h3C, 0);
        send_chans(16'hFFFC, 8'hA5, 0, 127, 128, 0, 0);
        send_chans(16'hFFFD, 8'hA5, 0, 127, 128, 0, 0);
        send_chans(16'hFFFE, 8'hA5, 0, 127, 1, 0, 0);
        send_chans(16'hFFFF, 8'hA5, 0, 127, 0, 0, 0);
        send_chans(16'h0000, 8'hA5, 0, 127, 0, 0, 0);
        send_chans(16'h0001, 8'hA5, 0, 127, 0, 0, 0);
        send_chans(16'h0002, 8'hA5, 0, 127, 0, 0, 0);
        idle(2);
        check("b2b_strobes", strobe_cnt - snap, 639);
        check("b2b_counter_frame", Counter_Frame, 16'h0002);
        check("b2b_locked", Locked, 1);
        check("b2b_last_channel", Counter_Channel, 7'd127);

        // Reset in the middle of a byte
        send_chans(16'h0003, 8'hA5, 0, 5, 0, 0, 0);
        idle(2);
        send_bit(1, 0); send_bit(0, 0); send_bit(1, 0);
        @(posedge clk);
        #2;
        Bit_Valid = 1'b0;
        check("pre_reset_bits", Counter_Bits, 3);
        RESET_N = 1'b0;
        #1;
        check("async_reset_outputs", outs, 0);
        @(negedge clk) RESET_N = 1'b1;
        repeat (50) @(negedge clk);
        check("idle_outputs", outs, 0);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
